// File: rtl/an_dec_pkg.sv
// an_dec_pkg: shared constants and types for the AN-code (A = 13) decode arbiter.
//   AN_A / CW_W / Q_W / R_W : code constant and field widths
//   BR_M / BR_K             : Barrett reciprocal, q_est = (cw * BR_M) >> BR_K
//   s2_t                    : payload held in the output stage
package an_dec_pkg;
  localparam int AN_A     = 13;
  localparam int CW_W     = 6;
  localparam int Q_W      = 3;
  localparam int R_W      = 4;
  localparam int BR_M     = 78;
  localparam int BR_K     = 10;
  // Wide enough for the largest supported requester count (8).
  localparam int ID_MAX_W = 3;

  typedef struct packed {
    logic [ID_MAX_W-1:0] id;
    logic [Q_W-1:0]      q;
    logic [R_W-1:0]      r;
    logic                err;
  } s2_t;
endpackage

// File: rtl/an_mod13_reduce.sv
// an_mod13_reduce: combinational Barrett reduction of a 6-bit AN codeword by 13.
//   i_cw  : codeword
//   o_q   : floor(cw / 13)
//   o_r   : cw mod 13
//   o_err : residue non-zero (codeword corrupted)
module an_mod13_reduce
  import an_dec_pkg::*;
(
  input  logic [CW_W-1:0] i_cw,
  output logic [Q_W-1:0]  o_q,
  output logic [R_W-1:0]  o_r,
  output logic            o_err
);
  logic [15:0] w_prod, w_q_est, w_r_est;

  assign w_prod  = 16'(i_cw) * 16'(BR_M);
  assign w_q_est = w_prod >> BR_K;
  assign w_r_est = 16'(i_cw) - 16'(AN_A) * w_q_est;

  // The estimate undershoots by at most one (cw = 13, 26, 39, 52), so a
  // single conditional subtract makes it exact over the whole 6-bit range.
  always_comb begin
    o_q = Q_W'(w_q_est);
    o_r = R_W'(w_r_est);
    if (w_r_est >= 16'(AN_A)) begin
      o_q = Q_W'(w_q_est + 16'd1);
      o_r = R_W'(w_r_est - 16'(AN_A));
    end
  end

  assign o_err = (o_r != '0);
endmodule

// File: rtl/an_decode_arbiter.sv
// an_decode_arbiter: round-robin shares one mod-13 AN decoder among NREQ
// requesters through a two-stage (S1 capture, S2 result) valid/ready pipeline.
//   clk, rst                 : clock, synchronous active-high reset
//   req_valid/req_codeword   : per-requester input, requester i at [i*6 +: 6]
//   req_ready                : one-hot (or zero) accept strobe
//   out_valid/out_ready      : result handshake
//   out_id/out_q/out_r/out_error : requester index, quotient, residue, residue != 0
//   clr_count, err_count     : clear and saturating count of errored results
// Optional feature macro: AN_ERR_CNT_EN (error counter; tied to 0 when undefined).
module an_decode_arbiter #(
  parameter  int NREQ  = 4,
  parameter  int CW_W  = 6,
  parameter  int CNT_W = 8,
  localparam int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*CW_W-1:0] req_codeword,
  output logic [NREQ-1:0]      req_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ID_W-1:0]      out_id,
  output logic [2:0]           out_q,
  output logic [3:0]           out_r,
  output logic                 out_error,
  input  logic                 clr_count,
  output logic [CNT_W-1:0]     err_count
);
  import an_dec_pkg::s2_t;
  import an_dec_pkg::ID_MAX_W;
  import an_dec_pkg::Q_W;
  import an_dec_pkg::R_W;

  logic [ID_W-1:0] r_last;
  logic            r_s1_valid;
  logic [ID_W-1:0] r_s1_id;
  logic [CW_W-1:0] r_s1_cw;
  logic            r_out_valid;
  s2_t             r_s2;

  logic [NREQ-1:0] w_grant;
  logic [ID_W-1:0] w_gnt_id;
  logic            w_found;
  int              w_idx;
  logic            w_s1_load, w_s2_load, w_acc;
  logic [Q_W-1:0]  w_q;
  logic [R_W-1:0]  w_r;
  logic            w_err;

  assign w_s2_load = !r_out_valid || out_ready;
  assign w_s1_load = !r_s1_valid || w_s2_load;

  // Scan from farthest to nearest after r_last so the nearest valid
  // requester is the final assignment and wins.
  always_comb begin
    w_grant  = '0;
    w_gnt_id = '0;
    w_found  = 1'b0;
    w_idx    = 0;
    for (int k = NREQ; k >= 1; k--) begin
      w_idx = (int'(r_last) + k) % NREQ;
      if (req_valid[w_idx]) begin
        w_grant  = NREQ'(1) << w_idx;
        w_gnt_id = ID_W'(w_idx);
        w_found  = 1'b1;
      end
    end
  end

  assign req_ready = w_grant & {NREQ{w_s1_load}};
  assign w_acc     = w_found && w_s1_load;

  an_mod13_reduce u_reduce (
    .i_cw  (r_s1_cw),
    .o_q   (w_q),
    .o_r   (w_r),
    .o_err (w_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last      <= ID_W'(NREQ - 1);
      r_s1_valid  <= 1'b0;
      r_s1_id     <= '0;
      r_s1_cw     <= '0;
      r_out_valid <= 1'b0;
      r_s2        <= '0;
    end else begin
      if (w_s1_load) begin
        r_s1_valid <= w_acc;
        if (w_acc) begin
          r_s1_id <= w_gnt_id;
          r_s1_cw <= req_codeword[int'(w_gnt_id)*CW_W +: CW_W];
          r_last  <= w_gnt_id;
        end
      end
      if (w_s2_load) begin
        r_out_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2.id  <= ID_MAX_W'(r_s1_id);
          r_s2.q   <= w_q;
          r_s2.r   <= w_r;
          r_s2.err <= w_err;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_id    = r_s2.id[ID_W-1:0];
  assign out_q     = r_s2.q;
  assign out_r     = r_s2.r;
  assign out_error = r_s2.err;

  // Upper id bits are always zero when NREQ needs fewer than ID_MAX_W bits.
  logic w_unused_id;
  assign w_unused_id = ^r_s2.id;

`ifdef AN_ERR_CNT_EN
  logic [CNT_W-1:0] r_err_cnt;
  always_ff @(posedge clk) begin
    if (rst || clr_count)
      r_err_cnt <= '0;
    else if (r_out_valid && out_ready && r_s2.err && (r_err_cnt != '1))
      r_err_cnt <= r_err_cnt + 1'b1;
  end
  assign err_count = r_err_cnt;
`else
  logic w_unused_clr;
  assign w_unused_clr = clr_count;
  assign err_count    = '0;
`endif
endmodule

// File: tb/tb_an_decode_arbiter.sv
module tb_an_decode_arbiter;
  localparam int NREQ  = 4;
  localparam int CW_W  = 6;
  localparam int CNT_W = 2;
`ifdef AN_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*CW_W-1:0] req_codeword;
  logic [NREQ-1:0]      req_ready;
  logic                 out_valid, out_ready;
  logic [1:0]           out_id;
  logic [2:0]           out_q;
  logic [3:0]           out_r;
  logic                 out_error;
  logic                 clr_count;
  logic [CNT_W-1:0]     err_count;

  always #5 clk = ~clk;

  an_decode_arbiter #(.NREQ(NREQ), .CW_W(CW_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_codeword(req_codeword),
    .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_id(out_id), .out_q(out_q), .out_r(out_r), .out_error(out_error),
    .clr_count(clr_count), .err_count(err_count)
  );

  typedef struct { int id; int q; int r; bit e; } exp_t;
  exp_t q_exp[$];
  int checks = 0, errors = 0;
  int exp_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  task automatic push(input int id, input int q, input int r);
    exp_t e;
    e.id = id; e.q = q; e.r = r; e.e = (r != 0);
    q_exp.push_back(e);
  endtask

  task automatic set_req(input int id, input int cw);
    req_valid[id] = 1'b1;
    req_codeword[id*CW_W +: CW_W] = CW_W'(cw);
  endtask

  // Keep presenting until every valid requester is accepted; drop each on accept.
  task automatic run_until_done(input int maxcyc, output int acc);
    logic [NREQ-1:0] hs;
    acc = 0;
    for (int n = 0; n < maxcyc && req_valid != '0; n++) begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk); #1;
      req_valid = req_valid & ~hs;
      acc += $countones(hs);
    end
    if (req_valid != '0) begin
      fail("accept_timeout");
      req_valid = '0;
    end
  endtask

  task automatic wait_drain(input int maxcyc);
    int n;
    for (n = 0; n < maxcyc && q_exp.size() != 0; n++) begin
      @(posedge clk); #1;
    end
    if (q_exp.size() != 0) begin
      fail("drain_timeout");
      q_exp.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    out_ready = 1'b1;
    clr_count = 1'b0;
    q_exp.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Scoreboard monitor: pops on every output handshake, tracks the counter,
  // and checks output stability across stalled cycles.
  logic       stall_prev = 1'b0;
  logic [9:0] prev_out, cur_out;
  bit         hs_err;
  exp_t       me;
  always @(negedge clk) begin
    cur_out = {out_id, out_q, out_r, out_error};
    if (rst) begin
      exp_cnt    = 0;
      stall_prev = 1'b0;
    end else begin
      chk("err_count", int'(err_count), exp_cnt);
      if (stall_prev) begin
        chk("stall_valid", int'(out_valid), 1);
        chk("stall_hold", int'(cur_out), int'(prev_out));
      end
      hs_err = 1'b0;
      if (out_valid && out_ready) begin
        if (q_exp.size() == 0) begin
          fail("unexpected_output");
          hs_err = out_error;
        end else begin
          me = q_exp.pop_front();
          chk("out_id", int'(out_id), me.id);
          chk("out_q", int'(out_q), me.q);
          chk("out_r", int'(out_r), me.r);
          chk("out_error", int'(out_error), int'(me.e));
          hs_err = me.e;
        end
      end
      if (CNT_EN) begin
        if (clr_count) exp_cnt = 0;
        else if (out_valid && out_ready && hs_err && exp_cnt < CNT_MAX) exp_cnt++;
      end
      stall_prev = out_valid && !out_ready;
      prev_out   = cur_out;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, t0;
    logic [NREQ-1:0] hs;
    rst = 1'b1; req_valid = '0; req_codeword = '0; out_ready = 1'b1; clr_count = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_req_ready", int'(req_ready), 0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_fields", int'({out_id, out_q, out_r, out_error}), 0);
    chk("rst_err_count", int'(err_count), 0);
    @(posedge clk); #1;

    // Single request, requester 2, cw = 27 -> q 2, r 1, error; latency check.
    set_req(2, 27); push(2, 2, 1);
    @(negedge clk);
    chk("t1_accept", int'(req_ready), 4'b0100);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    chk("t1_lat_edge_n", int'(out_valid), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t1_lat_edge_n1", int'(out_valid), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t1_count", int'(err_count), CNT_EN ? 1 : 0);
    @(posedge clk); #1;

    // Error-free codeword 39 -> q 3, r 0; counter unchanged.
    set_req(1, 39); push(1, 3, 0);
    run_until_done(10, a);
    wait_drain(10);
    @(negedge clk);
    chk("t2_count", int'(err_count), CNT_EN ? 1 : 0);
    @(posedge clk); #1;

    // Exhaustive back-to-back sweep on requester 0.
    t0 = int'($time);
    for (int cw = 0; cw < 64; cw++) begin
      set_req(0, cw); push(0, cw / 13, cw % 13);
      run_until_done(10, a);
    end
    chk("sweep_cycles", (int'($time) - t0) / 10, 64);
    wait_drain(20);

    // All requesters valid: grants 0,1,2,3 then 0,1,2,3.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, i * 13 + 1);
    push(0, 0, 1); push(1, 1, 1); push(2, 2, 1); push(3, 3, 1);
    t0 = int'($time);
    run_until_done(20, a);
    chk("rr_accepts", a, 4);
    chk("rr_cycles", (int'($time) - t0) / 10, 4);
    for (int i = 0; i < NREQ; i++) set_req(i, i * 13);
    push(0, 0, 0); push(1, 1, 0); push(2, 2, 0); push(3, 3, 0);
    run_until_done(20, a);
    wait_drain(20);

    // Backpressure: 5 stalled cycles, only two accepts fit.
    out_ready = 1'b0;
    set_req(0, 5); set_req(1, 52); set_req(2, 63); set_req(3, 12);
    push(0, 0, 5); push(1, 4, 0);
    a = 0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk); #1;
      req_valid = req_valid & ~hs;
      a += $countones(hs);
    end
    chk("bp_accepts", a, 2);
    @(negedge clk);
    chk("bp_ready_zero", int'(req_ready), 0);
    @(posedge clk); #1;
    push(2, 4, 11); push(3, 0, 12);
    out_ready = 1'b1;
    run_until_done(20, a);
    chk("bp_rest_accepts", a, 2);
    wait_drain(20);

    // Saturation: five errored results against a 2-bit counter.
    do_reset();
    for (int cw = 1; cw <= 5; cw++) begin
      set_req(0, cw); push(0, 0, cw);
      run_until_done(10, a);
    end
    wait_drain(20);
    @(negedge clk);
    chk("sat_count", int'(err_count), CNT_EN ? 3 : 0);
    @(posedge clk); #1;

    // Clear coinciding with an errored handshake: clear wins.
    out_ready = 1'b0;
    set_req(0, 7); push(0, 0, 7);
    run_until_done(10, a);
    a = 0;
    while (!out_valid && a < 10) begin
      @(posedge clk); #1;
      a++;
    end
    if (!out_valid) fail("clr_wait_valid");
    out_ready = 1'b1; clr_count = 1'b1;
    @(posedge clk); #1;
    clr_count = 1'b0;
    @(negedge clk);
    chk("clr_wins", int'(err_count), 0);
    @(posedge clk); #1;
    wait_drain(10);

    // Reset with two results in flight.
    out_ready = 1'b0;
    set_req(0, 10); set_req(1, 11);
    push(0, 0, 10); push(1, 0, 11);
    run_until_done(10, a);
    chk("mid_accepts", a, 2);
    rst = 1'b1;
    q_exp.delete();
    @(posedge clk); #1;
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_fields", int'({out_id, out_q, out_r, out_error}), 0);
    chk("mid_rst_count", int'(err_count), 0);
    rst = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_no_ghost", int'(out_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
